// File: rtl/texel_modulate.sv
// Texel/shade colour combiner: two-stage valid/ready pipeline applying
// REPLACE, MODULATE, DECAL or ADD per beat on signed Q4.12 RGBA.
module texel_modulate #(
    parameter int unsigned TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [15:0]      tex_r,
    input  logic [15:0]      tex_g,
    input  logic [15:0]      tex_b,
    input  logic [15:0]      tex_a,
    input  logic [15:0]      shd_r,
    input  logic [15:0]      shd_g,
    input  logic [15:0]      shd_b,
    input  logic [15:0]      shd_a,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_r,
    output logic [15:0]      out_g,
    output logic [15:0]      out_b,
    output logic [15:0]      out_a,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CW   = 16;
    localparam int unsigned PW   = 32;
    localparam int unsigned XW   = PW + 1;
    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_A = 3;
    localparam int unsigned FRAC = 12;

    localparam logic [1:0] MODE_REPLACE  = 2'b00;
    localparam logic [1:0] MODE_MODULATE = 2'b01;
    localparam logic [1:0] MODE_DECAL    = 2'b10;
    localparam logic [1:0] MODE_ADD      = 2'b11;

    localparam logic signed [XW-1:0] RND  = XW'(32'sd2048);
    localparam logic signed [XW-1:0] SMAX = XW'(32'sd32767);
    localparam logic signed [XW-1:0] SMIN = XW'(-32'sd32768);

    function automatic logic [CW-1:0] sat16(input logic signed [XW-1:0] v);
        logic [CW-1:0] r;
        if (v > SMAX) begin
            r = 16'h7FFF;
        end else if (v < SMIN) begin
            r = 16'h8000;
        end else begin
            r = v[CW-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [XW-1:0] round_q12(input logic signed [PW-1:0] p);
        return (XW'(p) + RND) >>> FRAC;
    endfunction

    function automatic logic signed [XW-1:0] add17(input logic signed [CW-1:0] a,
                                                   input logic signed [CW-1:0] b);
        logic signed [CW:0] s;
        s = (CW+1)'(a) + (CW+1)'(b);
        return XW'(s);
    endfunction

    logic                 s1_valid;
    logic                 s1_load;
    logic                 s2_load;
    logic [1:0]           s1_mode;
    logic [TAG_W-1:0]     s1_tag;
    logic signed [CW-1:0] tex_in  [NCH];
    logic signed [CW-1:0] shd_in  [NCH];
    logic signed [PW-1:0] prod_c  [NCH];
    logic signed [CW-1:0] s1_tex  [NCH];
    logic signed [CW-1:0] s1_shd  [NCH];
    logic signed [PW-1:0] s1_prod [NCH];
    logic [CW-1:0]        res_c   [NCH];

    // A stage accepts when empty or when its contents move on this cycle.
    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;

    always_comb begin
        tex_in[0] = tex_r;
        tex_in[1] = tex_g;
        tex_in[2] = tex_b;
        tex_in[3] = tex_a;
        shd_in[0] = shd_r;
        shd_in[1] = shd_g;
        shd_in[2] = shd_b;
        shd_in[3] = shd_a;
        for (int c = 0; c < NCH; c++) begin
            prod_c[c] = PW'(tex_in[c]) * PW'(shd_in[c]);
        end
    end

    // S1: operands, mode, tag and raw products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_REPLACE;
            s1_tag   <= '0;
            for (int c = 0; c < NCH; c++) begin
                s1_tex[c]  <= '0;
                s1_shd[c]  <= '0;
                s1_prod[c] <= '0;
            end
        end else if (s1_load) begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_tag   <= in_tag;
            for (int c = 0; c < NCH; c++) begin
                s1_tex[c]  <= tex_in[c];
                s1_shd[c]  <= shd_in[c];
                s1_prod[c] <= prod_c[c];
            end
        end
    end

    // Per-mode result selection; alpha follows shade in DECAL.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            res_c[c] = s1_tex[c];
            case (s1_mode)
                MODE_REPLACE:  res_c[c] = s1_tex[c];
                MODE_MODULATE: res_c[c] = sat16(round_q12(s1_prod[c]));
                MODE_DECAL:    res_c[c] = s1_tex[c];
                MODE_ADD:      res_c[c] = sat16(add17(s1_tex[c], s1_shd[c]));
                default:       res_c[c] = s1_tex[c];
            endcase
        end
        if (s1_mode == MODE_DECAL) begin
            res_c[CH_A] = s1_shd[CH_A];
        end
    end

    // S2: output register; data only moves when a real beat arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_a     <= '0;
            out_tag   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_r   <= res_c[0];
                out_g   <= res_c[1];
                out_b   <= res_c[2];
                out_a   <= res_c[3];
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_texel_modulate.sv
// Bench for texel_modulate: directed corner cases plus a random valid/ready
// stress run scored against an arithmetic reference model.
module tb_texel_modulate;

    localparam int unsigned TAG_W = 16;
    localparam logic [1:0] M_REP = 2'b00;
    localparam logic [1:0] M_MOD = 2'b01;
    localparam logic [1:0] M_DEC = 2'b10;
    localparam logic [1:0] M_ADD = 2'b11;

    typedef logic [3:0][15:0] quad_t;  // [0]=r [1]=g [2]=b [3]=a
    typedef struct packed {
        quad_t            c;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [15:0]      tex_r, tex_g, tex_b, tex_a;
    logic [15:0]      shd_r, shd_g, shd_b, shd_a;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_r, out_g, out_b, out_a;
    logic [TAG_W-1:0] out_tag;

    int vectors = 0;
    int miscompares = 0;

    texel_modulate #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .tex_r(tex_r), .tex_g(tex_g), .tex_b(tex_b), .tex_a(tex_a),
        .shd_r(shd_r), .shd_g(shd_g), .shd_b(shd_b), .shd_a(shd_a),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_a(out_a),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_chan(input logic [1:0] m, input logic [15:0] t,
                                             input logic [15:0] s, input bit is_a);
        int ti, si, v;
        ti = int'($signed(t));
        si = int'($signed(s));
        case (m)
            M_REP:   v = ti;
            M_MOD:   v = (ti * si + 2048) >>> 12;
            M_DEC:   v = is_a ? si : ti;
            default: v = ti + si;
        endcase
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic beat_t ref_beat(input logic [1:0] m, input quad_t t, input quad_t s,
                                       input logic [TAG_W-1:0] tag);
        beat_t b;
        for (int c = 0; c < 4; c++) b.c[c] = ref_chan(m, t[c], s[c], c == 3);
        b.tag = tag;
        return b;
    endfunction

    function automatic quad_t outs();
        return {out_a, out_b, out_g, out_r};
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h1000;
            3: return 16'($urandom_range(0, 4095));
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic quad_t rand_quad();
        quad_t q;
        for (int c = 0; c < 4; c++) q[c] = rand_val();
        return q;
    endfunction

    task automatic drive(input logic v, input logic [1:0] m, input quad_t t, input quad_t s,
                         input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_mode  = m;
        tex_r = t[0]; tex_g = t[1]; tex_b = t[2]; tex_a = t[3];
        shd_r = s[0]; shd_g = s[1]; shd_b = s[2]; shd_a = s[3];
        in_tag = tag;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, M_MOD, {4{16'h1000}}, {4{16'h1000}}, 16'hDEAD);
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || outs() !== '0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL reset_state valid=%b data=%h tag=%h expected 0/0/0", out_valid, outs(), out_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, M_REP, '0, '0, '0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%b expected 1", in_ready);
        end
        repeat (4) begin
            @(negedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_beat_dropped out_valid=%b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_modulate_basic();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, M_MOD, {4{16'h1000}}, {4{16'h0800}}, 16'h0011);
        @(negedge clk);
        drive(1'b0, M_REP, '0, '0, '0);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mod_latency_early out_valid=%b expected 0", out_valid);
        end
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || outs() !== {4{16'h0800}} || out_tag !== 16'h0011) begin
            miscompares++;
            $display("FAIL mod_basic valid=%b data=%h tag=%h expected 1/%h/0011",
                     out_valid, outs(), out_tag, {4{16'h0800}});
        end
    endtask

    task automatic test_round_sat();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, M_MOD, {16'h1000, 16'h8000, 16'h7FFF, 16'h0001},
              {16'h1000, 16'h7FFF, 16'h7FFF, 16'h0800}, 16'h0021);
        @(negedge clk);
        drive(1'b1, M_ADD, {16'h7000, 16'h0100, 16'h0200, 16'h8000},
              {16'h7000, 16'h0100, 16'h0300, 16'h8000}, 16'h0022);
        @(negedge clk);
        drive(1'b0, M_REP, '0, '0, '0);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_r !== 16'h0001) begin
            miscompares++;
            $display("FAIL mod_round_r valid=%b got=%h expected 0001", out_valid, out_r);
        end
        vectors++;
        if (out_g !== 16'h7FFF) begin
            miscompares++;
            $display("FAIL mod_sat_pos_g got=%h expected 7fff", out_g);
        end
        vectors++;
        if (out_b !== 16'h8000) begin
            miscompares++;
            $display("FAIL mod_sat_neg_b got=%h expected 8000", out_b);
        end
        vectors++;
        if (out_a !== 16'h1000 || out_tag !== 16'h0021) begin
            miscompares++;
            $display("FAIL mod_unity_a got=%h tag=%h expected 1000 tag 0021", out_a, out_tag);
        end
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_a !== 16'h7FFF) begin
            miscompares++;
            $display("FAIL add_sat_pos_a valid=%b got=%h expected 7fff", out_valid, out_a);
        end
        vectors++;
        if (out_r !== 16'h8000 || out_g !== 16'h0500 || out_b !== 16'h0200 || out_tag !== 16'h0022) begin
            miscompares++;
            $display("FAIL add_rgb got=%h/%h/%h tag=%h expected 8000/0500/0200 tag 0022",
                     out_r, out_g, out_b, out_tag);
        end
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL round_sat_bubble out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_mode_mix();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, M_REP, {16'h0400, 16'h0333, 16'h0222, 16'h0111}, {4{16'h0FFF}}, 16'h0031);
        @(negedge clk);
        drive(1'b1, M_DEC, {16'h0400, 16'h0AAA, 16'h0BBB, 16'h0CCC},
              {16'h0C00, 16'h0123, 16'h0456, 16'h0789}, 16'h0032);
        @(negedge clk);
        drive(1'b1, M_ADD, {16'h0800, 16'h0010, 16'h0020, 16'h0030},
              {16'h0400, 16'h0001, 16'h0002, 16'h0003}, 16'h0033);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_a !== 16'h0400 || out_r !== 16'h0111 || out_tag !== 16'h0031) begin
            miscompares++;
            $display("FAIL mix_replace valid=%b a=%h r=%h tag=%h expected 1/0400/0111/0031",
                     out_valid, out_a, out_r, out_tag);
        end
        @(negedge clk);
        drive(1'b0, M_REP, '0, '0, '0);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_a !== 16'h0C00 || out_r !== 16'h0CCC || out_b !== 16'h0AAA) begin
            miscompares++;
            $display("FAIL mix_decal valid=%b a=%h r=%h b=%h expected 1/0c00/0ccc/0aaa",
                     out_valid, out_a, out_r, out_b);
        end
        @(negedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_a !== 16'h0C00 || out_r !== 16'h0033 || out_tag !== 16'h0033) begin
            miscompares++;
            $display("FAIL mix_add valid=%b a=%h r=%h tag=%h expected 1/0c00/0033/0033",
                     out_valid, out_a, out_r, out_tag);
        end
    endtask

    task automatic test_backpressure();
        int  next_tag = 1;
        int  exp_tag  = 1;
        int  holds    = 0;
        int  tag_at_stall = 0;
        bit  seen  = 1'b0;
        bit  stall;
        for (int cyc = 0; cyc < 40 && exp_tag <= 6; cyc++) begin
            @(negedge clk);
            drive(next_tag <= 6, M_ADD, rand_quad(), rand_quad(), TAG_W'(next_tag));
            out_ready = 1'b1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                tag_at_stall = next_tag;
            end
            stall = seen && holds < 5;
            if (stall) begin
                out_ready = 1'b0;
                holds++;
            end
            #1;
            if (stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_tag !== TAG_W'(1) || in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_hold valid=%b tag=%0d in_ready=%b expected 1/1/0",
                             out_valid, out_tag, in_ready);
                end
            end else if (seen) begin
                vectors++;
                if (out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_gap out_valid=%b expected 1 (next tag %0d)", out_valid, exp_tag);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (out_tag !== TAG_W'(exp_tag)) begin
                    miscompares++;
                    $display("FAIL bp_order tag=%0d expected %0d", out_tag, exp_tag);
                end
                exp_tag++;
            end
            if (in_valid && in_ready) next_tag++;
        end
        vectors++;
        if (exp_tag != 7 || tag_at_stall != 3) begin
            miscompares++;
            $display("FAIL bp_complete delivered_upto=%0d accepted_before_stall=%0d expected 6/2",
                     exp_tag - 1, tag_at_stall - 1);
        end
        @(negedge clk);
        drive(1'b0, M_REP, '0, '0, '0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, M_MOD, {4{16'h1000}}, {4{16'h1000}}, 16'h0051);
        @(negedge clk);
        drive(1'b1, M_ADD, {4{16'h0100}}, {4{16'h0100}}, 16'h0052);
        @(negedge clk);
        drive(1'b0, M_REP, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || outs() !== '0 || out_tag !== '0) begin
            miscompares++;
            $display("FAIL midreset_clear valid=%b data=%h tag=%h expected 0/0/0", out_valid, outs(), out_tag);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_in_ready got=%b expected 1", in_ready);
        end
        repeat (4) begin
            @(negedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_ghost out_valid=%b tag=%h expected 0", out_valid, out_tag);
            end
        end
    endtask

    task automatic test_stress();
        beat_t q[$];
        beat_t exp_b, act_b, prev_b;
        bit    prev_stall = 1'b0;
        quad_t t, s;
        logic [1:0] m;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            t = rand_quad();
            s = rand_quad();
            m = 2'($urandom_range(0, 3));
            drive(cyc < 2900 && $urandom_range(0, 9) < 7, m, t, s, TAG_W'($urandom));
            out_ready = (cyc >= 2900) || ($urandom_range(0, 9) < 6);
            #1;
            act_b = {outs(), out_tag};
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || act_b !== prev_b) begin
                    miscompares++;
                    $display("FAIL stress_hold valid=%b got=%h expected %h", out_valid, act_b, prev_b);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stress_spurious got=%h expected no beat", act_b);
                end else begin
                    exp_b = q.pop_front();
                    if (act_b !== exp_b) begin
                        miscompares++;
                        $display("FAIL stress_data got=%h expected %h", act_b, exp_b);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(ref_beat(m, t, s, in_tag));
            prev_stall = out_valid && !out_ready;
            prev_b = act_b;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL stress_drain outstanding=%0d expected 0", q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, M_REP, '0, '0, '0);
        test_reset();
        test_modulate_basic();
        test_round_sat();
        test_mode_mix();
        test_backpressure();
        test_reset_mid();
        test_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
